isp_frame_ctrl: RTL and testbench
=================================

// Module: isp_frame_ctrl
// PURPOSE
//  Frame sequencer placed in front of the Bayer demosaic stage.
//  Tracks pixel/line position from href/vsync/de and validates frame geometry against WIDTH/HEIGHT.
//  Gates the sync strobes into the demosaic so only whole, well-formed frames pass.
//  Supplies the Bayer phase {odd_line, odd_pix} with a frame-synchronous pattern configuration.
// PARAMETERS
//  WIDTH   1920  active pixels per line
//  HEIGHT  960   active lines per frame
//  PW      12    pix_cnt width, >= clog2(WIDTH+1)
//  LW      11    line_cnt width, >= clog2(HEIGHT+1)
// PORTS
//  pclk         in   1   pixel clock; the only clock
//  rst          in   1   synchronous reset, active-high
//  cfg_enable   in   1   0 forces IDLE; outputs held low
//  cfg_bayer    in   2   pattern 0:RGGB 1:GRBG 2:GBRG 3:BGGR
//  cfg_valid    in   1   new cfg_bayer offered
//  cfg_ready    out  1   shadow slot free; transfer when valid&ready
//  in_href      in   1   line active
//  in_vsync     in   1   high = vertical blanking
//  in_de        in   1   pixel valid
//  out_href     out  1   gated href, 1-cycle registered
//  out_vsync    out  1   vsync, 1-cycle registered, never gated
//  out_de       out  1   gated de, 1-cycle registered
//  bayer_phase  out  2   {odd_line,odd_pix} XOR active cfg_bayer, aligned to out_de
//  sof          out  1   1-cycle pulse on first out_de of frame
//  eof          out  1   1-cycle pulse after HEIGHT-th line's href falls
//  frame_err    out  1   1-cycle pulse on geometry violation
//  pix_cnt      out  PW  de count within current line
//  line_cnt     out  LW  completed lines in current frame
// BEHAVIOUR
//  - Reset: all outputs 0 except cfg_ready=1; state=IDLE, active bayer=0, shadow empty.
//  - Edges from 1-cycle registered inputs; vs_fall = frame start, hr_fall = line end.
//  - FSM: IDLE -cfg_enable-> SYNC -vs_fall-> ACTIVE -HEIGHT-th hr_fall-> FLUSH -vsync high-> SYNC.
//  - Any state -> IDLE when cfg_enable=0; counters cleared, gated outputs 0 next cycle.
//  - Gating: out_href/out_de = registered input AND state==ACTIVE; out_vsync always passes.
//  - Line end in ACTIVE with pix_cnt!=WIDTH -> frame_err, go SYNC, drop remainder of frame.
//  - vsync rising in ACTIVE (line_cnt<HEIGHT) -> frame_err, go SYNC.
//  - href rising in FLUSH (extra line) -> frame_err, stay FLUSH, line not forwarded.
//  - pix_cnt +1 per de, clears on hr_fall; saturates at 2^PW-1.
//  - line_cnt +1 per hr_fall, clears on vs_fall.
//  - odd_pix toggles per forwarded de, cleared when href low; odd_line toggles per hr_fall, cleared on vsync.
//  - Config handshake: transfer latches shadow, cfg_ready->0 next cycle.
//  - Shadow commits to active bayer on vs_fall, or next cycle if state is IDLE/SYNC; then cfg_ready->1.
//  - Mid-frame cfg never changes bayer_phase of the current frame.
//  - vs_fall coinciding with cfg transfer: commit uses the newly latched value.
//  - sof and frame_err same cycle impossible; eof and frame_err mutually exclusive.
//  - Latency: all outputs 1 pclk after inputs.
// CONFIGURATION
//  ISP_FRAME_STATS_EN defined:
//   - adds out frame_cnt[15:0] (+1 per eof, wraps) and err_cnt[7:0] (+1 per frame_err, saturates at 255).
//   - both cleared by rst only.
//  ISP_FRAME_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package isp_pkg: bayer pattern localparams (BAYER_RGGB..BAYER_BGGR).
//  - isp_pkg: FSM state encoding (ST_IDLE, ST_SYNC, ST_ACTIVE, ST_FLUSH).
//  - One sub-module: isp_edge_det (registered rise/fall detector), instanced for href and vsync.
// TESTING (bench WIDTH=8, HEIGHT=4)
//  - Clean frame: 4 lines x 8 de -> sof once, eof once after 4th hr_fall, frame_err never, 32 out_de.
//  - Short line: 3rd line 7 de -> frame_err pulse at its hr_fall, no eof, out_de low until next frame.
//  - Early vsync: vsync high after 2 lines -> frame_err; next clean frame -> sof, eof.
//  - Config: cfg_bayer=3 mid-frame -> current frame phase uses old pattern, cfg_ready=0 until vs_fall.
//  - Config commit: at vs_fall first bayer_phase=2'b11 and cfg_ready=1.
//  - Disable: cfg_enable=0 mid-line -> out_de/out_href 0 next cycle; re-enable waits for vs_fall.
//  - Reset: rst asserted mid-frame -> cfg_ready=1, all else 0, bayer pattern back to RGGB.
//  - Stats (macro on): 3 clean frames + 1 error -> frame_cnt=3, err_cnt=1.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared definitions for the ISP front-end: Bayer pattern codes and frame FSM states.
package isp_pkg;

   localparam logic [1:0] BAYER_RGGB = 2'd0;
   localparam logic [1:0] BAYER_GRBG = 2'd1;
   localparam logic [1:0] BAYER_GBRG = 2'd2;
   localparam logic [1:0] BAYER_BGGR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

endpackage

// File: rtl/isp_edge_det.sv
// Registered edge detector: samples din once, reports level and rise/fall of the sampled signal.
module isp_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic q;
   logic q_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= '0;
         q_d <= '0;
      end else begin
         q   <= din;
         q_d <= q;
      end
   end

   assign level = q;
   assign rise  = q & ~q_d;
   assign fall  = ~q & q_d;

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame sequencer ahead of the demosaic: validates geometry, gates sync strobes, supplies Bayer phase.
// Optional build macro ISP_FRAME_STATS_EN adds frame_cnt/err_cnt statistics outputs.
module isp_frame_ctrl
   import isp_pkg::*;
#(
   parameter int WIDTH  = 1920,
   parameter int HEIGHT = 960,
   parameter int PW     = 12,
   parameter int LW     = 11
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          cfg_enable,
   input  logic [1:0]    cfg_bayer,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic          in_href,
   input  logic          in_vsync,
   input  logic          in_de,
   output logic          out_href,
   output logic          out_vsync,
   output logic          out_de,
   output logic [1:0]    bayer_phase,
   output logic          sof,
   output logic          eof,
   output logic          frame_err,
   output logic [PW-1:0] pix_cnt,
   output logic [LW-1:0] line_cnt
`ifdef ISP_FRAME_STATS_EN
   ,
   output logic [15:0]   frame_cnt,
   output logic [7:0]    err_cnt
`endif
);

   logic   href_q, hr_rise, hr_fall;
   logic   vsync_q, vs_rise, vs_fall;
   logic   de_q;
   state_t state, state_nxt;

   isp_edge_det u_href_det (
      .clk   (pclk),
      .rst   (rst),
      .din   (in_href),
      .level (href_q),
      .rise  (hr_rise),
      .fall  (hr_fall)
   );

   isp_edge_det u_vsync_det (
      .clk   (pclk),
      .rst   (rst),
      .din   (in_vsync),
      .level (vsync_q),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   always_ff @(posedge pclk) begin
      if (rst) de_q <= '0;
      else     de_q <= in_de;
   end

   logic active, flush, fwd_de, line_done, line_ok, last_line;
   logic eof_c, err_line, err_vs, err_extra;

   assign active    = (state == ST_ACTIVE);
   assign flush     = (state == ST_FLUSH);
   assign fwd_de    = active & de_q;
   assign line_done = active & hr_fall;
   assign line_ok   = (pix_cnt == PW'(WIDTH));
   assign last_line = (line_cnt == LW'(HEIGHT - 1));
   assign eof_c     = line_done & line_ok & last_line;
   assign err_line  = line_done & ~line_ok;
   // A vsync rise landing on the closing href fall of a complete frame is not an error.
   assign err_vs    = active & vs_rise & ~eof_c;
   assign err_extra = flush & hr_rise;

   always_ff @(posedge pclk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (cfg_enable) state_nxt = ST_SYNC;
         ST_SYNC:   if (vs_fall) state_nxt = ST_ACTIVE;
         ST_ACTIVE: begin
            if (err_line || err_vs) state_nxt = ST_SYNC;
            else if (eof_c)         state_nxt = ST_FLUSH;
         end
         ST_FLUSH:  if (vsync_q) state_nxt = ST_SYNC;
         default:   state_nxt = ST_IDLE;
      endcase
      if (!cfg_enable) state_nxt = ST_IDLE;
   end

   logic odd_pix, odd_line;

   always_ff @(posedge pclk) begin
      if (rst || !cfg_enable) begin
         pix_cnt  <= '0;
         line_cnt <= '0;
         odd_pix  <= '0;
         odd_line <= '0;
      end else begin
         if (hr_fall || vs_fall)           pix_cnt <= '0;
         else if (fwd_de && pix_cnt != '1) pix_cnt <= pix_cnt + PW'(1);

         if (vs_fall)        line_cnt <= '0;
         else if (line_done) line_cnt <= line_cnt + LW'(1);

         if (!href_q)     odd_pix <= '0;
         else if (fwd_de) odd_pix <= ~odd_pix;

         if (vsync_q)        odd_line <= '0;
         else if (line_done) odd_line <= ~odd_line;
      end
   end

   logic       shadow_full, shadow_wait;
   logic [1:0] shadow_val, bayer_act;
   logic       xfer;

   assign xfer      = cfg_valid & ~shadow_full;
   assign cfg_ready = ~shadow_full;

   // A shadow loaded mid-frame is held for the next frame start, even if the FSM drops back to SYNC.
   always_ff @(posedge pclk) begin
      if (rst) begin
         shadow_full <= '0;
         shadow_wait <= '0;
         shadow_val  <= BAYER_RGGB;
         bayer_act   <= BAYER_RGGB;
      end else if (xfer && vs_fall) begin
         bayer_act <= cfg_bayer;
      end else if (xfer) begin
         shadow_full <= 1'b1;
         shadow_val  <= cfg_bayer;
         shadow_wait <= active | flush;
      end else if (shadow_full && (vs_fall || !shadow_wait)) begin
         bayer_act   <= shadow_val;
         shadow_full <= '0;
         shadow_wait <= '0;
      end
   end

   assign out_href    = href_q & active;
   assign out_de      = fwd_de;
   assign out_vsync   = vsync_q;
   assign bayer_phase = fwd_de ? ({odd_line, odd_pix} ^ bayer_act) : '0;
   assign sof         = fwd_de & href_q & ~vsync_q & (pix_cnt == '0) & (line_cnt == '0);
   assign eof         = eof_c;
   assign frame_err   = err_line | err_vs | err_extra;

`ifdef ISP_FRAME_STATS_EN
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (eof_c) frame_cnt <= frame_cnt + 16'd1;
         if (frame_err && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Directed bench for isp_frame_ctrl with an 8x4 frame geometry.
`timescale 1ns/1ps
module tb_isp_frame_ctrl;

   localparam int WIDTH  = 8;
   localparam int HEIGHT = 4;
   localparam int PW     = 4;
   localparam int LW     = 3;

   logic          pclk = 1'b0;
   logic          rst, cfg_enable, cfg_valid, cfg_ready;
   logic [1:0]    cfg_bayer;
   logic          in_href, in_vsync, in_de;
   logic          out_href, out_vsync, out_de;
   logic [1:0]    bayer_phase;
   logic          sof, eof, frame_err;
   logic [PW-1:0] pix_cnt;
   logic [LW-1:0] line_cnt;
`ifdef ISP_FRAME_STATS_EN
   logic [15:0]   frame_cnt;
   logic [7:0]    err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int n_sof, n_eof, n_err, n_de;

   always #5 pclk = ~pclk;

   isp_frame_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PW(PW), .LW(LW)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .cfg_enable  (cfg_enable),
      .cfg_bayer   (cfg_bayer),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .in_href     (in_href),
      .in_vsync    (in_vsync),
      .in_de       (in_de),
      .out_href    (out_href),
      .out_vsync   (out_vsync),
      .out_de      (out_de),
      .bayer_phase (bayer_phase),
      .sof         (sof),
      .eof         (eof),
      .frame_err   (frame_err),
      .pix_cnt     (pix_cnt),
      .line_cnt    (line_cnt)
`ifdef ISP_FRAME_STATS_EN
      ,
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt)
`endif
   );

   // Drive one cycle of inputs, then sample the outputs they produce.
   task automatic cyc(input logic h, input logic v, input logic d);
      in_href  = h;
      in_vsync = v;
      in_de    = d;
      @(posedge pclk);
      @(negedge pclk);
      if (sof)       n_sof++;
      if (eof)       n_eof++;
      if (frame_err) n_err++;
      if (out_de)    n_de++;
   endtask

   task automatic clear_counts();
      n_sof = 0; n_eof = 0; n_err = 0; n_de = 0;
   endtask

   task automatic vblank();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_lines(input int n, input int short_idx, input int short_len,
                             input logic [1:0] pat, input int cfg_line);
      int limit;
      int len;
      logic [1:0] exp_ph;
      if (short_idx >= 0)  limit = short_idx + 1;
      else if (n < HEIGHT) limit = n;
      else                 limit = HEIGHT;
      for (int l = 0; l < n; l++) begin
         len = (l == short_idx) ? short_len : WIDTH;
         for (int i = 0; i < len; i++) begin
            if (l == cfg_line && i == 0) begin
               cfg_valid = 1'b1;
               cfg_bayer = 2'd3;
            end
            cyc(1'b1, 1'b0, 1'b1);
            cfg_valid = 1'b0;
            exp_ph = {l[0], i[0]} ^ pat;
            checks++;
            if (l < limit) begin
               if (out_de !== 1'b1 || bayer_phase !== exp_ph) begin
                  errors++;
                  $display("FAIL pixel l%0d p%0d: out_de=%b phase=%0d, expected out_de=1 phase=%0d",
                           l, i, out_de, bayer_phase, exp_ph);
               end
            end else if (out_de !== 1'b0) begin
               errors++;
               $display("FAIL dropped pixel l%0d p%0d: out_de=%b, expected 0", l, i, out_de);
            end
            if (l == 0 && i == 0) begin
               checks++;
               if (sof !== 1'b1) begin
                  errors++;
                  $display("FAIL sof on first pixel: got %b expected 1", sof);
               end
            end
         end
         cyc(1'b0, 1'b0, 1'b0);
         if (l == short_idx) begin
            checks++;
            if (frame_err !== 1'b1) begin
               errors++;
               $display("FAIL short line err at hr_fall: got %b expected 1", frame_err);
            end
         end
         if (l == HEIGHT - 1 && short_idx < 0) begin
            checks++;
            if (eof !== 1'b1) begin
               errors++;
               $display("FAIL eof at last hr_fall: got %b expected 1", eof);
            end
         end
         cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic check_counts(input string name, input int e_sof, input int e_eof,
                               input int e_err, input int e_de);
      checks++;
      if (n_sof !== e_sof || n_eof !== e_eof || n_err !== e_err || n_de !== e_de) begin
         errors++;
         $display("FAIL %s counts: sof=%0d eof=%0d err=%0d de=%0d, expected %0d %0d %0d %0d",
                  name, n_sof, n_eof, n_err, n_de, e_sof, e_eof, e_err, e_de);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({out_href, out_vsync, out_de, bayer_phase, sof, eof, frame_err} !== 8'd0
          || pix_cnt !== '0 || line_cnt !== '0) begin
         errors++;
         $display("FAIL %s outputs: href=%b vs=%b de=%b ph=%0d sof=%b eof=%b err=%b pix=%0d line=%0d, expected all 0",
                  name, out_href, out_vsync, out_de, bayer_phase, sof, eof, frame_err, pix_cnt, line_cnt);
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s cfg_ready: got %b expected 1", name, cfg_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_enable = 1'b0; cfg_valid = 1'b0; cfg_bayer = 2'd0;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      check_idle_outputs("reset");
      rst = 1'b0; cfg_enable = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_clean_frame();
      clear_counts();
      vblank();
      send_lines(4, -1, 0, 2'd0, -1);
      check_counts("clean", 1, 1, 0, 32);
      checks++;
      if (line_cnt !== LW'(HEIGHT)) begin
         errors++;
         $display("FAIL clean line_cnt: got %0d expected %0d", line_cnt, HEIGHT);
      end
   endtask

   task automatic test_short_line();
      clear_counts();
      vblank();
      send_lines(4, 2, 7, 2'd0, -1);
      check_counts("short", 1, 0, 1, 23);
   endtask

   task automatic test_early_vsync();
      clear_counts();
      vblank();
      send_lines(2, -1, 0, 2'd0, -1);
      vblank();
      check_counts("early vsync", 1, 0, 1, 16);
      clear_counts();
      send_lines(4, -1, 0, 2'd0, -1);
      check_counts("after early vsync", 1, 1, 0, 32);
   endtask

   task automatic test_extra_line();
      clear_counts();
      vblank();
      send_lines(5, -1, 0, 2'd0, -1);
      check_counts("extra line", 1, 1, 1, 32);
   endtask

   task automatic test_config_midframe();
      clear_counts();
      vblank();
      send_lines(4, -1, 0, 2'd0, 1);
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL cfg_ready after mid-frame cfg: got %b expected 0", cfg_ready);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL cfg_ready during vsync: got %b expected 0", cfg_ready);
      end
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL cfg_ready after vs_fall: got %b expected 1", cfg_ready);
      end
      send_lines(4, -1, 0, 2'd3, -1);
      check_counts("config", 2, 2, 0, 64);
   endtask

   task automatic test_config_sync();
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cfg_valid = 1'b1; cfg_bayer = 2'd1;
      cyc(1'b0, 1'b1, 1'b0);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL cfg_ready after sync transfer: got %b expected 0", cfg_ready);
      end
      cyc(1'b0, 1'b1, 1'b0);
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL cfg_ready after sync commit: got %b expected 1", cfg_ready);
      end
      cyc(1'b0, 1'b0, 1'b0);
      cfg_valid = 1'b1; cfg_bayer = 2'd2;
      cyc(1'b0, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL cfg_ready after coincident transfer: got %b expected 1", cfg_ready);
      end
      clear_counts();
      send_lines(4, -1, 0, 2'd2, -1);
      check_counts("config sync", 1, 1, 0, 32);
   endtask

   task automatic test_long_line();
      clear_counts();
      vblank();
      for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 1'b1);
      checks++;
      if (pix_cnt !== '1) begin
         errors++;
         $display("FAIL pix_cnt saturation: got %0d expected 15", pix_cnt);
      end
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (frame_err !== 1'b1) begin
         errors++;
         $display("FAIL long line err: got %b expected 1", frame_err);
      end
      cyc(1'b0, 1'b0, 1'b0);
      check_counts("long line", 1, 0, 1, 18);
   endtask

   task automatic test_disable();
      clear_counts();
      vblank();
      send_lines(1, -1, 0, 2'd2, -1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
      cfg_enable = 1'b0;
      cyc(1'b1, 1'b0, 1'b1);
      checks++;
      if (out_de !== 1'b0 || out_href !== 1'b0 || pix_cnt !== '0 || line_cnt !== '0) begin
         errors++;
         $display("FAIL disable: de=%b href=%b pix=%0d line=%0d, expected all 0",
                  out_de, out_href, pix_cnt, line_cnt);
      end
      cfg_enable = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < WIDTH; i++) cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      check_counts("disable", 1, 0, 0, 11);
      clear_counts();
      vblank();
      send_lines(4, -1, 0, 2'd2, -1);
      check_counts("re-enable", 1, 1, 0, 32);
   endtask

   task automatic test_reset_midframe();
      clear_counts();
      vblank();
      cfg_valid = 1'b1; cfg_bayer = 2'd3;
      cyc(1'b1, 1'b0, 1'b1);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL cfg_ready before mid reset: got %b expected 0", cfg_ready);
      end
      cyc(1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b1);
      check_idle_outputs("mid reset");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      clear_counts();
      vblank();
      send_lines(4, -1, 0, 2'd0, -1);
      check_counts("after mid reset", 1, 1, 0, 32);
   endtask

`ifdef ISP_FRAME_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 3; f++) begin
         vblank();
         send_lines(4, -1, 0, 2'd0, -1);
      end
      vblank();
      send_lines(4, 1, 5, 2'd0, -1);
      checks++;
      if (frame_cnt !== 16'd3 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL stats: frame_cnt=%0d err_cnt=%0d, expected 3 1", frame_cnt, err_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; cfg_enable = 1'b0; cfg_valid = 1'b0; cfg_bayer = 2'd0;
      in_href = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
      clear_counts();
      test_reset();
      test_clean_frame();
      test_short_line();
      test_early_vsync();
      test_extra_line();
      test_config_midframe();
      test_config_sync();
      test_long_line();
      test_disable();
      test_reset_midframe();
`ifdef ISP_FRAME_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
